// File: rtl/compressor.sv
// AXI-stream zero-word compressor: each 256-bit beat becomes a mask word plus its nonzero
// words, tokens are packed back-to-back into output beats, and the packet tail is zero-padded.
module compressor #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DATA   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wrtEn,
  input  logic [DATA_WIDTH*NUM_DATA-1:0] data_in,
  input  logic                           tvalid_in,
  input  logic                           tlast_in,
  input  logic                           tready_in,
  output logic [DATA_WIDTH*NUM_DATA-1:0] data_out,
  output logic                           tready_out,
  output logic                           tvalid_out,
  output logic                           tlast_out
);

  localparam int BEAT_W    = DATA_WIDTH * NUM_DATA;
  localparam int BUF_WORDS = 2 * NUM_DATA;
  localparam int BUF_W     = DATA_WIDTH * BUF_WORDS;
  localparam int TOK_W     = DATA_WIDTH * (NUM_DATA + 1);
  localparam int CNT_W     = $clog2(BUF_WORDS + 1);

  localparam logic [CNT_W-1:0] NUM_C  = CNT_W'(NUM_DATA);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM_DATA - 1);
  localparam logic [CNT_W-1:0] ZERO_C = '0;

  // Packing buffer, word 0 in the low bits. Every word at or above count_q is kept zero,
  // so emission is a plain shift and token insertion is a plain OR.
  logic [BUF_W-1:0]    buf_q, buf_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                flush_q;
  logic                bypass_q;
  logic                pkt_start_q;

  logic                emit, accept, use_bypass;
  logic [CNT_W-1:0]    shift, base, tok_len;
  logic [NUM_DATA-1:0] mask;
  logic [TOK_W-1:0]    tok_vec;
  logic [BUF_W-1:0]    ins_vec;
  int                  idx;

  assign data_out   = buf_q[BEAT_W-1:0];
  assign tvalid_out = (count_q >= NUM_C) || (flush_q && (count_q != ZERO_C));
  assign tlast_out  = flush_q && (count_q <= NUM_C);
  assign emit       = tvalid_out && tready_in;
  assign shift      = !emit ? ZERO_C : ((count_q >= NUM_C) ? NUM_C : count_q);
  assign base       = count_q - shift;
  // Space is judged after this cycle's emission, so tready_out depends on tready_in.
  assign tready_out = !flush_q && (base <= LAST_C);
  assign accept     = tvalid_in && tready_out;

  // The first beat of a packet decides the mode from wrtEn directly; later beats use the latch.
  assign use_bypass = pkt_start_q ? !wrtEn : bypass_q;

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    mask    = '0;
    tok_vec = '0;
    tok_len = '0;
    idx     = 0;
    for (int i = 0; i < NUM_DATA; i++) begin
      mask[i] = (data_in[i*DATA_WIDTH +: DATA_WIDTH] != '0);
    end
    if (use_bypass) begin
      tok_vec[BEAT_W-1:0] = data_in;
      tok_len             = NUM_C;
    end else begin
      tok_vec[DATA_WIDTH-1:0] = DATA_WIDTH'(mask);
      idx = 1;
      for (int i = 0; i < NUM_DATA; i++) begin
        if (mask[i]) begin
          tok_vec[idx*DATA_WIDTH +: DATA_WIDTH] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
          idx = idx + 1;
        end
      end
      tok_len = CNT_W'(idx);
    end
  end

  // Unused token slots are zero, so OR-ing at position base never disturbs queued words.
  always_comb begin
    ins_vec = '0;
    if (accept) begin
      ins_vec = BUF_W'(tok_vec) << (DATA_WIDTH * int'(base));
    end
    buf_d   = (emit ? (buf_q >> BEAT_W) : buf_q) | ins_vec;
    count_d = accept ? (base + tok_len) : base;
  end

  // NOTE: the buffer is reset along with the control state: a mid-packet reset must show
  // data_out = 0 at once, and the zero-above-count invariant depends on it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register
      // sees the pre-edge values of the others.
      buf_q       <= '0;
      count_q     <= '0;
      flush_q     <= 1'b0;
      bypass_q    <= 1'b0;
      pkt_start_q <= 1'b1;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      if (accept) begin
        if (pkt_start_q) bypass_q <= !wrtEn;
        pkt_start_q <= tlast_in;
        if (tlast_in) flush_q <= 1'b1;
      end else if (emit && tlast_out) begin
        flush_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_compressor.sv
// Scoreboard bench for compressor: a packet-level reference model pushes expected output
// beats, and an independent monitor pops and compares on every output handshake.
module tb_compressor;

  localparam int DW = 32;
  localparam int ND = 8;
  localparam int BW = DW * ND;

  typedef logic [BW-1:0] beat_t;
  typedef struct {
    beat_t data;
    logic  last;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset_n = 1'b1;
  logic  wrtEn = 1'b1;
  beat_t data_in = '0;
  logic  tvalid_in = 1'b0;
  logic  tlast_in = 1'b0;
  logic  tready_in = 1'b1;
  beat_t data_out;
  logic  tready_out, tvalid_out, tlast_out;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    bp_mode = 0;   // 0: always ready, 1: random ready, 2: held not-ready
  bit    track = 1'b0;
  int    run_len = 0;
  int    max_run = 0;

  compressor #(.DATA_WIDTH(DW), .NUM_DATA(ND)) dut (
    .clk(clk), .reset(reset_n), .wrtEn(wrtEn), .data_in(data_in),
    .tvalid_in(tvalid_in), .tlast_in(tlast_in), .tready_in(tready_in),
    .data_out(data_out), .tready_out(tready_out), .tvalid_out(tvalid_out),
    .tlast_out(tlast_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference model: a packet is a flat word stream cut into 8-word beats, last one padded.
  task automatic push_model(input beat_t beats[$], input bit bypass);
    logic [DW-1:0] words[$];
    logic [DW-1:0] w;
    logic [DW-1:0] m;
    int nb;
    beat_t v;
    foreach (beats[b]) begin
      m = '0;
      for (int k = 0; k < ND; k++) if (beats[b][k*DW +: DW] != 0) m = m + (32'd1 << k);
      if (!bypass) words.push_back(m);
      for (int k = 0; k < ND; k++) begin
        w = beats[b][k*DW +: DW];
        if (bypass || w != 0) words.push_back(w);
      end
    end
    nb = (words.size() + ND - 1) / ND;
    for (int b = 0; b < nb; b++) begin
      v = '0;
      for (int k = 0; k < ND; k++)
        if (b*ND + k < words.size()) v[k*DW +: DW] = words[b*ND + k];
      exp_q.push_back('{data: v, last: (b == nb - 1)});
    end
  endtask

  function automatic beat_t rand_beat(input int zero_pct);
    beat_t v;
    for (int k = 0; k < ND; k++)
      v[k*DW +: DW] = ($urandom_range(0, 99) < zero_pct) ? 32'd0 : ($urandom() | 32'd1);
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 with tvalid_in low.
  task automatic send_packet(input beat_t beats[$], input bit wrt, input bit use_model,
                             input int max_gap);
    int gap;
    int guard;
    if (use_model) push_model(beats, !wrt);
    foreach (beats[i]) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      tvalid_in = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      tvalid_in = 1'b1;
      data_in   = beats[i];
      tlast_in  = (i == beats.size() - 1);
      wrtEn     = (i == 0) ? wrt : 1'($urandom_range(0, 1));
      guard = 0;
      @(negedge clk);
      while (!tready_out && guard < 500) begin @(negedge clk); guard++; end
      if (guard >= 500) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: tready_out stayed 0 for %0d cycles, expected 1", guard);
      end
      @(posedge clk); #1;
    end
    tvalid_in = 1'b0;
    tlast_in  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || tvalid_out) && guard < 2000) begin @(negedge clk); guard++; end
    check(name, BW'(exp_q.size()), '0);
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk); #2;
    tready_in = (bp_mode == 0) ? 1'b1 : (bp_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: scoreboard pop on handshake, plus output stability while stalled.
  initial begin
    bit    prev_stalled;
    beat_t prev_data;
    logic  prev_last;
    exp_t  e;
    prev_stalled = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stalled = 1'b0;
      end else begin
        if (prev_stalled) begin
          check("hold_valid", BW'(tvalid_out), BW'(1'b1));
          check("hold_data", data_out, prev_data);
          check("hold_last", BW'(tlast_out), BW'(prev_last));
        end
        if (tvalid_out && tready_in) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_beat: got %h, expected no beat", data_out);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", data_out, e.data);
            check("beat_last", BW'(tlast_out), BW'(e.last));
          end
        end
        prev_stalled = tvalid_out && !tready_in;
        prev_data    = data_out;
        prev_last    = tlast_out;
      end
    end
  end

  // Longest run of consecutive input stalls while a beat is offered.
  initial forever begin
    @(negedge clk);
    if (track && tvalid_in && !tready_out) run_len++;
    else run_len = 0;
    if (track && run_len > max_run) max_run = run_len;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t pk[$];
    beat_t hdr, a, b;
    logic [DW-1:0] x1, x2;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_tvalid", BW'(tvalid_out), '0);
    check("rst_tlast", BW'(tlast_out), '0);
    check("rst_data", data_out, '0);
    check("rst_tready", BW'(tready_out), BW'(1'b1));
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1) header packet with hand-derived expectations
    hdr = {32'h0, 32'h0, 32'h06000000, 32'h0000dc05, 32'h28000008, 32'h0, 32'h0, 32'h0};
    x1 = 32'hBA98FEDC;
    x2 = 32'hFEDCBA98;
    exp_q.push_back('{data: {32'h06000000, 32'h0000dc05, 32'h28000008, 32'h00000038,
                             32'h06000000, 32'h0000dc05, 32'h28000008, 32'h00000038}, last: 1'b0});
    exp_q.push_back('{data: {32'h06000000, 32'h0000dc05, 32'h28000008, 32'h00000038,
                             32'h06000000, 32'h0000dc05, 32'h28000008, 32'h00000038}, last: 1'b0});
    exp_q.push_back('{data: {x1, x1, x1, x1, x1, x1, x1, 32'h000000FF}, last: 1'b0});
    exp_q.push_back('{data: {x2, x2, x2, x2, x2, x2, 32'h000000FF, x1}, last: 1'b0});
    exp_q.push_back('{data: {192'h0, x2, x2}, last: 1'b1});
    pk = '{hdr, hdr, hdr, hdr, {8{x1}}, {8{x2}}};
    send_packet(pk, 1'b1, 1'b0, 0);
    wait_drain("t1_drain");

    // 2) three all-zero beats -> one padded beat of zero mask words
    exp_q.push_back('{data: '0, last: 1'b1});
    pk = '{beat_t'(0), beat_t'(0), beat_t'(0)};
    send_packet(pk, 1'b1, 1'b0, 0);
    wait_drain("t2_drain");

    // 3) bypass, one-cycle latency
    a = rand_beat(30);
    b = rand_beat(30);
    exp_q.push_back('{data: a, last: 1'b0});
    exp_q.push_back('{data: b, last: 1'b1});
    tvalid_in = 1'b1; data_in = a; tlast_in = 1'b0; wrtEn = 1'b0;
    @(negedge clk);
    check("t3_ready_a", BW'(tready_out), BW'(1'b1));
    @(posedge clk); #1;
    data_in = b; tlast_in = 1'b1; wrtEn = 1'b1;
    @(negedge clk);
    check("t3_out_a", data_out, a);
    check("t3_valid_a", BW'(tvalid_out), BW'(1'b1));
    check("t3_ready_b", BW'(tready_out), BW'(1'b1));
    @(posedge clk); #1;
    tvalid_in = 1'b0; tlast_in = 1'b0;
    @(negedge clk);
    check("t3_out_b", data_out, b);
    check("t3_last_b", BW'(tlast_out), BW'(1'b1));
    @(posedge clk); #1;
    wait_drain("t3_drain");

    // 4) full-pattern stream, stalls at most one cycle at a time
    pk.delete();
    for (int i = 0; i < 27; i++) pk.push_back(rand_beat(0));
    track = 1'b1;
    send_packet(pk, 1'b1, 1'b1, 0);
    track = 1'b0;
    check("t4_stall_run_le1", BW'(max_run <= 1), BW'(1'b1));
    check("t4_stall_seen", BW'(max_run >= 1), BW'(1'b1));
    wait_drain("t4_drain");

    // 5) downstream held off for 5 cycles mid-packet
    pk.delete();
    for (int i = 0; i < 6; i++) pk.push_back(rand_beat(0));
    fork
      send_packet(pk, 1'b1, 1'b1, 0);
      begin
        repeat (3) @(posedge clk);
        #1 bp_mode = 2;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t5_tready_low", BW'(tready_out), '0);
        check("t5_tvalid_high", BW'(tvalid_out), BW'(1'b1));
        @(posedge clk);
        #1 bp_mode = 0;
      end
    join
    wait_drain("t5_drain");

    // Random packets, random modes, idle gaps and backpressure
    bp_mode = 1;
    for (int p = 0; p < 24; p++) begin
      pk.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) pk.push_back(rand_beat($urandom_range(0, 100)));
      send_packet(pk, ($urandom_range(0, 3) != 0), 1'b1, 2);
    end
    bp_mode = 0;
    wait_drain("rand_drain");

    // 6) reset mid-packet, then a compressed packet from count 0
    bp_mode = 2;
    @(posedge clk); #1;
    tvalid_in = 1'b1; data_in = rand_beat(0); tlast_in = 1'b0; wrtEn = 1'b0;
    @(posedge clk); #1;
    tvalid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_pre_valid", BW'(tvalid_out), BW'(1'b1));
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_tvalid", BW'(tvalid_out), '0);
    check("t6_rst_tlast", BW'(tlast_out), '0);
    check("t6_rst_data", data_out, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bp_mode = 0;
    @(posedge clk); #1;
    pk.delete();
    for (int i = 0; i < 3; i++) pk.push_back(rand_beat(50));
    send_packet(pk, 1'b1, 1'b1, 0);
    wait_drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
